frame_receiver: RTL and testbench



---
 rtl/link_pkg.sv | 10 +
 rtl/frame_checker.sv | 13 +
 rtl/frame_receiver.sv | 94 +++++++++
 tb/tb_frame_receiver.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared definitions for the RTS/CTS reliable link: frame geometry and the
// receiver handshake states.
package link_pkg;
  localparam int DATA_W  = 64;
  localparam int FRAME_W = DATA_W + 2;
  localparam int PAR_IDX = DATA_W;
  localparam int SEQ_IDX = DATA_W + 1;

  typedef enum logic [1:0] {IDLE, CHECK, ACK} state_t;
endpackage

// File: rtl/frame_checker.sv
// Combinational frame qualification: even parity over payload+parity bit and
// alternating-bit duplicate detection against the expected sequence bit.
module frame_checker #(
  parameter int DATA_W = 64
) (
  input  logic [0:DATA_W+1] frame,
  input  logic              exp_seq,
  output logic              parity_ok,
  output logic              is_dup
);
  assign parity_ok = ~(^frame[0:DATA_W]);
  assign is_dup    = frame[DATA_W+1] != exp_seq;
endmodule

// File: rtl/frame_receiver.sv
// Receiving end of the RTS/CTS link: latches a frame, checks it, ACK/NAKs on
// CTS and delivers clean, non-duplicate payloads to the local consumer.
module frame_receiver #(
  parameter int DATA_W = link_pkg::DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RTS,
  input  logic [0:DATA_W+1] data,
  output logic              CTS,
  output logic              nak,
  output logic [0:DATA_W-1] data_out,
  output logic              data_valid,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  dup_count
);
  import link_pkg::state_t;

  state_t            state, state_d;
  logic [0:DATA_W+1] frame_q;
  logic              exp_seq;
  logic              parity_ok, is_dup;
  logic              latch, deliver, err_inc, dup_inc, cts_d, nak_d;

  frame_checker #(.DATA_W(DATA_W)) u_chk (
    .frame     (frame_q),
    .exp_seq   (exp_seq),
    .parity_ok (parity_ok),
    .is_dup    (is_dup)
  );

  always_comb begin
    state_d = state;
    latch   = 1'b0;
    deliver = 1'b0;
    err_inc = 1'b0;
    dup_inc = 1'b0;
    cts_d   = 1'b0;
    nak_d   = 1'b0;
    unique case (state)
      link_pkg::IDLE: begin
        if (RTS) begin
          latch   = 1'b1;
          state_d = link_pkg::CHECK;
        end
      end
      link_pkg::CHECK: begin
        // RTS is not sampled here: a dropped RTS is seen one cycle later in ACK
        state_d = link_pkg::ACK;
        cts_d   = 1'b1;
        nak_d   = ~parity_ok;
        err_inc = ~parity_ok;
        dup_inc = parity_ok & is_dup;
        deliver = parity_ok & ~is_dup;
      end
      link_pkg::ACK: begin
        if (RTS) begin
          cts_d = 1'b1;
          nak_d = nak;
        end else begin
          state_d = link_pkg::IDLE;
        end
      end
      default: state_d = link_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= link_pkg::IDLE;
      frame_q    <= '0;
      exp_seq    <= 1'b0;
      CTS        <= 1'b0;
      nak        <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      err_count  <= '0;
      dup_count  <= '0;
    end else begin
      state      <= state_d;
      CTS        <= cts_d;
      nak        <= nak_d;
      data_valid <= deliver;
      if (latch)   frame_q  <= data;
      if (deliver) begin
        data_out <= frame_q[0:DATA_W-1];
        exp_seq  <= ~exp_seq;
      end
      if (err_inc && err_count != '1) err_count <= err_count + 1'b1;
      if (dup_inc && dup_count != '1) dup_count <= dup_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_frame_receiver.sv
// Scoreboard bench for frame_receiver: the sender side pushes the expected
// ACK outcome per frame, an independent monitor pops it on each CTS rise.
module tb_frame_receiver;
  localparam int DW = 64;

  typedef struct {
    logic        nak;
    logic        dv;
    logic [63:0] dout;
    logic [7:0]  err;
    logic [7:0]  dup;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          RTS = 1'b0;
  logic [0:DW+1] data = '0;
  logic          CTS, nak, data_valid;
  logic [0:DW-1] data_out;
  logic [7:0]    err_count, dup_count;

  frame_receiver #(.DATA_W(DW), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .RTS(RTS), .data(data), .CTS(CTS), .nak(nak),
    .data_out(data_out), .data_valid(data_valid),
    .err_count(err_count), .dup_count(dup_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];

  // reference model state
  bit          m_seq;
  int          m_err, m_dup;
  logic [63:0] m_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_seq = 1'b0; m_err = 0; m_dup = 0; m_last = '0;
  endtask

  // build a frame, predict its outcome from the protocol rules, run the handshake
  task automatic send(input logic [63:0] pl, input bit seq, input bit corrupt, input int hold);
    logic [0:DW+1] f;
    exp_t e;
    int lat;
    f = {pl, ^pl, seq};
    if (corrupt) f[5] = ~f[5];
    if ($countones(f[0:DW]) % 2 != 0) begin
      e.nak = 1'b1; e.dv = 1'b0;
      m_err = (m_err < 255) ? m_err + 1 : 255;
    end else if (seq != m_seq) begin
      e.nak = 1'b0; e.dv = 1'b0;
      m_dup = (m_dup < 255) ? m_dup + 1 : 255;
    end else begin
      e.nak = 1'b0; e.dv = 1'b1;
      m_last = f[0:DW-1];
      m_seq = ~m_seq;
    end
    e.dout = m_last; e.err = 8'(m_err); e.dup = 8'(m_dup);
    sb.push_back(e);
    @(negedge clk);
    data = f; RTS = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1 lat++;
    end while (!CTS && lat < 20);
    chk("cts_latency", 64'(lat), 64'd2);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      data = {$urandom, $urandom, 2'($urandom)};
    end
    @(negedge clk);
    RTS = 1'b0; data = {$urandom, $urandom, 2'($urandom)};
    @(posedge clk); #1;
    chk("cts_fall", 64'(CTS), 64'd0);
  endtask

  // monitor: compare on each CTS rise, watch nak stability and stray data_valid
  initial begin
    bit   cts_q = 1'b0;
    logic nak_hold = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cts_q = 1'b0;
      end else if (CTS && !cts_q) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("nak", 64'(nak), 64'(e.nak));
          chk("data_valid", 64'(data_valid), 64'(e.dv));
          chk("data_out", 64'(data_out), e.dout);
          chk("err_count", 64'(err_count), 64'(e.err));
          chk("dup_count", 64'(dup_count), 64'(e.dup));
        end
        nak_hold = nak;
        cts_q = 1'b1;
      end else begin
        if (CTS) chk("nak_stable", 64'(nak), 64'(nak_hold));
        else if (nak) chk("nak_idle", 64'(nak), 64'd0);
        if (data_valid) chk("stray_data_valid", 64'(data_valid), 64'd0);
        cts_q = CTS;
      end
    end
  end

  initial begin
    bit s;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_cts", 64'(CTS), 64'd0);
    chk("rst_nak", 64'(nak), 64'd0);
    chk("rst_dv", 64'(data_valid), 64'd0);
    chk("rst_dout", 64'(data_out), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    chk("rst_dup", 64'(dup_count), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed: clean, duplicate, corrupted, retransmit, long hold
    send(64'hDEADBEEF_01234567, 1'b0, 1'b0, 0);
    send(64'hDEADBEEF_01234567, 1'b0, 1'b0, 0);
    send(64'hCAFEF00D_55AA55AA, 1'b1, 1'b1, 1);
    send(64'hCAFEF00D_55AA55AA, 1'b1, 1'b0, 0);
    send(64'h0123456789ABCDEF, 1'b0, 1'b0, 10);

    // reset while the frame sits in CHECK
    @(negedge clk);
    data = {64'hFFFF0000FFFF0000, 1'b0, m_seq}; RTS = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("arst_cts", 64'(CTS), 64'd0);
    chk("arst_nak", 64'(nak), 64'd0);
    chk("arst_dv", 64'(data_valid), 64'd0);
    chk("arst_dout", 64'(data_out), 64'd0);
    chk("arst_err", 64'(err_count), 64'd0);
    chk("arst_dup", 64'(dup_count), 64'd0);
    model_reset();
    RTS = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_cts", 64'(CTS), 64'd0);
    chk("post_rst_dout", 64'(data_out), 64'd0);
    // exp_seq must be back at 0: a seq=0 frame is delivered
    send(64'h1122334455667788, 1'b0, 1'b0, 0);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      s = ($urandom_range(3) == 0) ? ~m_seq : m_seq;
      send({$urandom, $urandom}, s, $urandom_range(3) == 0, $urandom_range(3));
    end

    // error counter saturation
    for (int i = 0; i < 260; i++) send({$urandom, $urandom}, m_seq, 1'b1, 0);
    repeat (2) @(negedge clk);
    chk("err_saturated", 64'(err_count), 64'd255);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
